// File: rtl/coefficient_load_sequencer.sv
// Copies NUM_COEFF words from the coefficient staging buffer into the coefficient register file
// once the FIR datapath is idle. Load requests that arrive mid-load are merged into a single follow-up load.
module coefficient_load_sequencer #(
  parameter int NUM_COEFF = 4,
  parameter int COEFF_W   = 16,
  localparam int IDX_W    = $clog2(NUM_COEFF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_req,
  input  logic               fir_busy,
  input  logic [COEFF_W-1:0] src_rdata,
  output logic               src_ren,
  output logic [IDX_W-1:0]   src_addr,
  output logic               coeff_we,
  output logic [IDX_W-1:0]   coeff_sel,
  output logic [COEFF_W-1:0] coeff_data,
  output logic               loading,
  output logic               load_done
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFF - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             pending;

  // Requests seen outside IDLE collapse into one pending reload, which DONE consumes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_req) state <= WAIT_IDLE;
        end
        WAIT_IDLE: begin
          if (load_req) pending <= 1'b1;
          if (!fir_busy) begin
            state <= READ;
            idx   <= '0;
          end
        end
        READ: begin
          if (load_req) pending <= 1'b1;
          state <= WRITE;
        end
        WRITE: begin
          if (load_req) pending <= 1'b1;
          if (idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= READ;
          end
        end
        DONE: begin
          pending <= 1'b0;
          state   <= (pending || load_req) ? WAIT_IDLE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data lands one cycle after READ, so the WRITE state passes it straight through.
  assign loading    = (state == WAIT_IDLE) || (state == READ) || (state == WRITE);
  assign src_ren    = (state == READ);
  assign src_addr   = (state == READ) ? idx : '0;
  assign coeff_we   = (state == WRITE);
  assign coeff_sel  = (state == WRITE) ? idx : '0;
  assign coeff_data = (state == WRITE) ? src_rdata : '0;
  assign load_done  = (state == DONE);

endmodule

// File: tb/tb_coefficient_load_sequencer.sv
// Directed bench for coefficient_load_sequencer: checks per-cycle sequencing, the fir_busy stall, merging of pending requests,
// abort on reset, and back-to-back loads.
module tb_coefficient_load_sequencer;

  logic        clk;
  logic        rst;
  logic        load_req;
  logic        fir_busy;
  logic [15:0] src_rdata;
  logic        src_ren;
  logic [1:0]  src_addr;
  logic        coeff_we;
  logic [1:0]  coeff_sel;
  logic [15:0] coeff_data;
  logic        loading;
  logic        load_done;

  logic [15:0] buffer [4];
  logic [15:0] shadow [4];
  int          compareCount;
  int          mismatchCount;
  int          writeCount;
  int          doneCount;
  int          w0;
  int          d0;

  coefficient_load_sequencer #(.NUM_COEFF(4), .COEFF_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .fir_busy   (fir_busy),
    .src_rdata  (src_rdata),
    .src_ren    (src_ren),
    .src_addr   (src_addr),
    .coeff_we   (coeff_we),
    .coeff_sel  (coeff_sel),
    .coeff_data (coeff_data),
    .loading    (loading),
    .load_done  (load_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Staging buffer model with one cycle of read latency; it returns a marker value when not read.
  always @(posedge clk) begin
    if (src_ren) src_rdata <= buffer[src_addr];
    else         src_rdata <= 16'hDEAD;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Shadow register file and event counters, sampled shortly after each rising edge.
  always begin
    @(posedge clk);
    #2;
    checkOutput("ren_we_overlap", {31'b0, src_ren & coeff_we}, 32'd0);
    if (coeff_we) begin
      writeCount++;
      shadow[coeff_sel] = coeff_data;
    end
    if (load_done) doneCount++;
  end

  task automatic applyStimulus(input logic req, input logic busy);
    load_req = req;
    fir_busy = busy;
  endtask

  task automatic stepCycle();
    @(negedge clk);
  endtask

  task automatic setBuffer(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    buffer[0] = a;
    buffer[1] = b;
    buffer[2] = c;
    buffer[3] = d;
  endtask

  // Entered in the READ cycle for idx 0; leaves at the cycle after the last WRITE. reqMask[c] drives load_req into cycle c.
  task automatic checkLoadBody(input string tag, input logic [7:0] reqMask);
    for (int k = 0; k < 4; k++) begin
      checkOutput({tag, "_read_ren"}, {31'b0, src_ren}, 32'd1);
      checkOutput({tag, "_read_addr"}, {30'b0, src_addr}, k);
      checkOutput({tag, "_read_we"}, {31'b0, coeff_we}, 32'd0);
      checkOutput({tag, "_read_loading"}, {31'b0, loading}, 32'd1);
      load_req = reqMask[2*k];
      stepCycle();
      checkOutput({tag, "_write_we"}, {31'b0, coeff_we}, 32'd1);
      checkOutput({tag, "_write_sel"}, {30'b0, coeff_sel}, k);
      checkOutput({tag, "_write_data"}, {16'b0, coeff_data}, {16'b0, buffer[k]});
      checkOutput({tag, "_write_loading"}, {31'b0, loading}, 32'd1);
      checkOutput({tag, "_write_done"}, {31'b0, load_done}, 32'd0);
      load_req = reqMask[2*k+1];
      stepCycle();
    end
    load_req = 1'b0;
  endtask

  task automatic checkDoneCycle(input string tag);
    checkOutput({tag, "_done_pulse"}, {31'b0, load_done}, 32'd1);
    checkOutput({tag, "_done_loading"}, {31'b0, loading}, 32'd0);
    checkOutput({tag, "_done_we"}, {31'b0, coeff_we}, 32'd0);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_loading"}, {31'b0, loading}, 32'd0);
    checkOutput({tag, "_done"}, {31'b0, load_done}, 32'd0);
    checkOutput({tag, "_ren"}, {31'b0, src_ren}, 32'd0);
    checkOutput({tag, "_we"}, {31'b0, coeff_we}, 32'd0);
  endtask

  task automatic checkWaitIdle(input string tag);
    checkOutput({tag, "_loading"}, {31'b0, loading}, 32'd1);
    checkOutput({tag, "_ren"}, {31'b0, src_ren}, 32'd0);
    checkOutput({tag, "_we"}, {31'b0, coeff_we}, 32'd0);
    checkOutput({tag, "_done"}, {31'b0, load_done}, 32'd0);
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    writeCount    = 0;
    doneCount     = 0;
    for (int i = 0; i < 4; i++) shadow[i] = 16'h0;
    setBuffer(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0);

    // Reset held for two cycles while load_req is high.
    for (int i = 0; i < 2; i++) begin
      stepCycle();
      checkIdle("rst");
      checkOutput("rst_addr", {30'b0, src_addr}, 32'd0);
      checkOutput("rst_sel", {30'b0, coeff_sel}, 32'd0);
      checkOutput("rst_data", {16'b0, coeff_data}, 32'd0);
    end
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0);
    stepCycle();
    checkIdle("post_rst");

    // Basic load.
    w0 = writeCount;
    d0 = doneCount;
    applyStimulus(1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0);
    checkWaitIdle("basic_wait");
    stepCycle();
    checkLoadBody("basic", 8'h00);
    checkDoneCycle("basic");
    stepCycle();
    checkIdle("basic_end");
    checkOutput("basic_writes", writeCount - w0, 32'd4);
    checkOutput("basic_dones", doneCount - d0, 32'd1);

    // Busy stall: five cycles in WAIT_IDLE, then fir_busy is raised again mid-load and ignored.
    setBuffer(16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04);
    applyStimulus(1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checkWaitIdle("busy_wait");
      if (i == 4) fir_busy = 1'b0;
      stepCycle();
    end
    fir_busy = 1'b1;
    checkLoadBody("busy", 8'h00);
    checkDoneCycle("busy");
    fir_busy = 1'b0;
    stepCycle();
    checkIdle("busy_end");

    // Three requests during a load merge into exactly one follow-up load.
    setBuffer(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    w0 = writeCount;
    d0 = doneCount;
    applyStimulus(1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0);
    checkWaitIdle("pend_wait1");
    stepCycle();
    checkLoadBody("pend1", 8'b0001_0101);
    checkDoneCycle("pend1");
    stepCycle();
    checkWaitIdle("pend_wait2");
    stepCycle();
    checkLoadBody("pend2", 8'h00);
    checkDoneCycle("pend2");
    stepCycle();
    checkIdle("pend_end");
    stepCycle();
    checkIdle("pend_no_third");
    checkOutput("pend_writes", writeCount - w0, 32'd8);
    checkOutput("pend_dones", doneCount - d0, 32'd2);

    // Reset during the WRITE of idx 1 aborts the load; slots already written keep their values.
    setBuffer(16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3);
    w0 = writeCount;
    d0 = doneCount;
    applyStimulus(1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) stepCycle();
    checkOutput("abort_write_sel", {30'b0, coeff_sel}, 32'd1);
    checkOutput("abort_write_data", {16'b0, coeff_data}, 32'h0000A1A1);
    rst = 1'b1;
    stepCycle();
    checkIdle("abort_rst");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      checkIdle("abort_quiet");
    end
    checkOutput("abort_writes", writeCount - w0, 32'd2);
    checkOutput("abort_dones", doneCount - d0, 32'd0);
    checkOutput("abort_slot0", {16'b0, shadow[0]}, 32'h0000A0A0);
    checkOutput("abort_slot1", {16'b0, shadow[1]}, 32'h0000A1A1);
    checkOutput("abort_slot2", {16'b0, shadow[2]}, 32'h00003333);
    checkOutput("abort_slot3", {16'b0, shadow[3]}, 32'h00004444);
    applyStimulus(1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0);
    checkWaitIdle("restart_wait");
    stepCycle();
    checkLoadBody("restart", 8'h00);
    checkDoneCycle("restart");
    stepCycle();
    checkIdle("restart_end");
    checkOutput("restart_slot3", {16'b0, shadow[3]}, 32'h0000A3A3);

    // A request in the DONE cycle chains straight into the next load without passing through IDLE.
    setBuffer(16'h5005, 16'h6006, 16'h7007, 16'h8008);
    w0 = writeCount;
    d0 = doneCount;
    applyStimulus(1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0);
    stepCycle();
    checkLoadBody("chain1", 8'h00);
    checkDoneCycle("chain1");
    applyStimulus(1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0);
    checkWaitIdle("chain_wait");
    stepCycle();
    checkLoadBody("chain2", 8'h00);
    checkDoneCycle("chain2");
    stepCycle();
    checkIdle("chain_end");
    stepCycle();
    checkIdle("chain_no_third");
    checkOutput("chain_writes", writeCount - w0, 32'd8);
    checkOutput("chain_dones", doneCount - d0, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
